// File: rtl/root_seq_if.sv
// Handshake bundle between root_seq and its neighbours: operand stream in, result stream out,
// and the start/busy link to the square-root core. Names carry the sequencer's own direction.
interface root_seq_if #(
  parameter int DEPTH = 4,
  parameter int W     = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid_i;
  logic [W-1:0]  in_data_i;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [W-1:0]  out_x_o;
  logic [W-1:0]  out_y_o;
  logic          out_ready_i;
  logic          root_start_o;
  logic [W-1:0]  root_x_o;
  logic          root_busy_i;
  logic [W-1:0]  root_y_i;
  logic [LW-1:0] level_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i, root_busy_i, root_y_i,
    output in_ready_o, out_valid_o, out_x_o, out_y_o, root_start_o, root_x_o, level_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i, root_busy_i, root_y_i,
    input  in_ready_o, out_valid_o, out_x_o, out_y_o, root_start_o, root_x_o, level_o
  );
endinterface

// File: rtl/root_seq.sv
// root_seq: operand FIFO plus launch/capture sequencer wrapped around the integer square-root core.
// Define ROOT_SEQ_PERF_EN to add saturating perf_ops_o / perf_stall_o counters.
module root_seq #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  root_seq_if.slave   bus
`ifdef ROOT_SEQ_PERF_EN
  ,
  output logic [15:0] perf_ops_o,
  output logic [15:0] perf_stall_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  op_x_q, op_x_d;
  logic [W-1:0]  root_x_q, root_x_d;
  logic [W-1:0]  out_x_q, out_x_d;
  logic [W-1:0]  out_y_q, out_y_d;
  logic          root_start_q, root_start_d;
  logic          out_valid_q, out_valid_d;
  logic          push, pop;

  assign bus.in_ready_o   = (level_q != FULL);
  assign bus.level_o      = level_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_x_o      = out_x_q;
  assign bus.out_y_o      = out_y_q;
  assign bus.root_start_o = root_start_q;
  assign bus.root_x_o     = root_x_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    op_x_d       = op_x_q;
    root_x_d     = root_x_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    root_start_d = 1'b0;
    out_valid_d  = out_valid_q && !bus.out_ready_i;
    push         = bus.in_valid_i && (level_q != FULL);
    pop          = 1'b0;

    // Launch waits for an empty result slot, so a capture can never overwrite unread data.
    unique case (state_q)
      S_IDLE: begin
        if (level_q != '0 && !out_valid_q) begin
          pop          = 1'b1;
          op_x_d       = mem[rd_ptr_q];
          root_x_d     = mem[rd_ptr_q];
          root_start_d = 1'b1;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.root_busy_i) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!bus.root_busy_i) state_d = S_CAPTURE;
      S_CAPTURE: begin
        out_y_d     = bus.root_y_i;
        out_x_d     = op_x_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and level alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= bus.in_data_i;
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      op_x_q       <= '0;
      root_x_q     <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      root_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      op_x_q       <= op_x_d;
      root_x_q     <= root_x_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      root_start_q <= root_start_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifdef ROOT_SEQ_PERF_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  // A stall is an IDLE cycle with work queued but the result slot still occupied.
  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (state_q == S_CAPTURE && perf_ops_q != 16'hFFFF)
      perf_ops_d = perf_ops_q + 16'd1;
    if (state_q == S_IDLE && level_q != '0 && out_valid_q && perf_stall_q != 16'hFFFF)
      perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops_o   = perf_ops_q;
  assign perf_stall_o = perf_stall_q;
`endif
endmodule

// File: doc/root_seq.md
Name: root_seq

Overview:
- Front-end sequencer for the 8-bit integer square-root core.
- Buffers operands from a valid/ready producer in a small FIFO and launches the core through its start/busy handshake, one operation at a time.
- Captures each result when busy falls and presents operand plus root on a valid/ready result port.
- Sits directly upstream and downstream of the root core; the core is instantiated beside it, not inside it.

Parameters:
- DEPTH, 4, operand FIFO depth in entries; power of two, minimum 2.
- W, 8, operand and root width; must match the core.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  operand valid.
- in_data_i  in  W  operand x.
- in_ready_o  out  1  FIFO can accept an operand.
- out_valid_o  out  1  result slot holds a result.
- out_x_o  out  W  operand belonging to the held result.
- out_y_o  out  W  floor(sqrt(out_x_o)) from the core.
- out_ready_i  in  1  consumer takes the result.
- root_start_o  out  1  to core start_i.
- root_x_o  out  W  to core x_bi.
- root_busy_i  in  1  from core busy_o.
- root_y_i  in  W  from core y_bo.
- level_o  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, immediate):
  - FIFO empty; level_o=0; in_ready_o=1.
  - out_valid_o=0, out_x_o=0, out_y_o=0.
  - root_start_o=0, root_x_o=0; state IDLE.
- FIFO:
  - Push when in_valid_i && in_ready_o.
  - in_ready_o = (level_o != DEPTH).
  - Pop occurs only on LAUNCH entry.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when full is not possible (in_ready_o=0); when not full, level_o is unchanged.
- State machine, one operation in flight:
  - IDLE: FIFO non-empty and out_valid_o==0 -> LAUNCH. Pop the head into an internal op_x register and drive root_x_o=head.
  - LAUNCH: root_start_o=1 for exactly this one cycle; root_x_o held -> WAIT_BUSY.
  - WAIT_BUSY: root_start_o=0; root_busy_i==1 -> WAIT_DONE; otherwise stay. Covers a core held in reset.
  - WAIT_DONE: root_busy_i==0 -> CAPTURE; otherwise stay.
  - CAPTURE: register out_y_o<=root_y_i, out_x_o<=op_x, out_valid_o<=1 -> IDLE.
- Core timing:
  - busy rises 1 cycle after start and stays high 5 cycles.
  - root_y_i is valid from the cycle busy is low.
  - Push to out_valid_o latency: 9 cycles (IDLE 1, LAUNCH 1, WAIT_BUSY 1, WAIT_DONE 5, CAPTURE 1).
- Output slot:
  - out_valid_o clears on out_valid_o && out_ready_i.
  - Data stays stable while out_valid_o=1 && !out_ready_i.
  - A new launch is gated on an empty slot, so capture never overwrites unconsumed data.
  - A slot cleared in cycle N permits a launch decision in cycle N+1.
- root_x_o holds its last value between operations.
- Reset mid-operation: all state is discarded and no result is emitted. The core resets independently.
- Arithmetic: none beyond pointer and level counters; level counter width log2(DEPTH)+1.

Optional Feature:
- Macro ROOT_SEQ_PERF_EN.
- Defined:
  - Adds output ports perf_ops_o (16 bit) and perf_stall_o (16 bit), both reset to 0.
  - perf_ops_o increments on each CAPTURE.
  - perf_stall_o increments each cycle the FIFO is non-empty and out_valid_o==1 in IDLE (backpressure stall).
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single op: push x=200 with out_ready_i=1 -> out_valid_o high 9 cycles after push with out_x_o=200, out_y_o=14; exactly one root_start_o pulse.
- Boundaries: push 0, 1, 255, 64 back-to-back -> results in order y=0, 1, 15, 8; level_o peaks at 3 and returns to 0.
- Backpressure: out_ready_i=0, push 5 operands with DEPTH=4 -> 1 result held stable (x=first operand); FIFO accepts the remaining 4; in_ready_o=0 when level_o=4; no second root_start_o until out_ready_i=1.
- Full plus drain: hold in_valid_i with in_ready_o=0 -> no push, level_o stays 4; then release out_ready_i -> all 5 results in order, no duplicates.
- Reset mid-op: assert rst_i during WAIT_DONE -> outputs immediately at reset values, FIFO empty, no out_valid_o pulse afterwards.
- PERF (macro defined): 3 ops with 4 stall cycles forced -> perf_ops_o=3, perf_stall_o=4.
